// File: rtl/edge_scan_ctrl_pkg.sv
// Shared definitions for the EDGE scan-chain controller: FSM state encodings
// and small state-decoding helpers used by the controller and its bench.
package edge_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } scan_state_t;

    // Chain is in shift mode (TE high, QN latches held) in these states.
    function automatic logic is_shift(input scan_state_t s);
        return (s == S_LOAD) || (s == S_UNLOAD);
    endfunction

    function automatic logic is_busy(input scan_state_t s);
        return (s == S_LOAD) || (s == S_CAPTURE) || (s == S_UNLOAD);
    endfunction

endpackage

// File: rtl/edge_scan_shreg.sv
// W-bit register with parallel load and MSB-first shift (serial in at the LSB);
// holds its value when neither load nor shift is requested.
module edge_scan_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         sout
);

    // Shift written as a left shift plus OR so W=1 needs no special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= (q << 1) | W'(sin);
        end
    end

    assign sout = q[W-1];

endmodule

// File: rtl/edge_scan_ctrl.sv
// EDGE scan-chain controller: shifts a pattern in, pulses one capture cycle,
// shifts the response out and compares it against the expected vector.
import edge_scan_ctrl_pkg::*;

module edge_scan_ctrl #(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 CP,
    input  logic                 RN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic                 chain_tq,
    output logic                 TI,
    output logic                 TE,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] cap_out,
    output logic                 mismatch
);

    localparam int CNT_W = ($clog2(CHAIN_LEN) > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_last;
    logic                 accept, load_shift, unl_shift, done_entry;
    logic [CHAIN_LEN-1:0] load_q, unl_q, exp_q, cap_nxt;
    logic                 unl_msb;
    logic                 unused_taps;

    assign cnt_last = (cnt == LAST);

    // The last unload sample lands in the same edge that enters DONE, so the
    // captured vector is taken from the shift register's next value.
    assign cap_nxt = (unl_q << 1) | CHAIN_LEN'(chain_tq);

    // Only TI leaves the load register; the unload MSB is read via unl_q.
    assign unused_taps = ^{load_q, unl_msb};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        accept     = 1'b0;
        load_shift = 1'b0;
        unl_shift  = 1'b0;
        done_entry = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_shift = 1'b1;
                if (cnt_last) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_UNLOAD;
            S_UNLOAD: begin
                unl_shift = 1'b1;
                if (cnt_last) begin
                    done_entry = 1'b1;
                    state_nxt  = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge RN) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!RN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            cnt      <= '0;
            exp_q    <= '0;
            TE       <= 1'b0;
            en       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cap_out  <= '0;
            mismatch <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                exp_q <= exp_in;
            end else if (load_shift || unl_shift) begin
                cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
            end
            TE   <= is_shift(state_nxt);
            en   <= !is_shift(state_nxt);
            busy <= is_busy(state_nxt);
            done <= (state_nxt == S_DONE);
            if (done_entry) begin
                cap_out  <= cap_nxt;
                mismatch <= (cap_nxt != exp_q);
            end
        end
    end

    // Load path: pattern latched at start, driven out MSB first, zeros behind it.
    edge_scan_shreg #(.W(CHAIN_LEN)) u_load (
        .clk   (CP),
        .rst_n (RN),
        .load  (accept),
        .d     (pat_in),
        .shift (load_shift),
        .sin   (1'b0),
        .q     (load_q),
        .sout  (TI)
    );

    // Unload path: first sample (last cell) ends up in the MSB.
    edge_scan_shreg #(.W(CHAIN_LEN)) u_unload (
        .clk   (CP),
        .rst_n (RN),
        .load  (accept),
        .d     ({CHAIN_LEN{1'b0}}),
        .shift (unl_shift),
        .sin   (chain_tq),
        .q     (unl_q),
        .sout  (unl_msb)
    );

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Directed bench for edge_scan_ctrl: an 8-cell and a 1-cell chain model with
// D = ~Q capture, checked against hand-computed results.
module tb_edge_scan_ctrl;
    import edge_scan_ctrl_pkg::*;

    localparam int N = 8;

    logic         cp = 1'b0;
    logic         rn;
    logic         start;
    logic [N-1:0] pat_in, exp_in, cap_out;
    logic         chain_tq, ti, te, en, busy, done, mismatch;
    logic [N-1:0] chain = '0;

    logic         start1;
    logic [0:0]   pat1, exp1, cap1;
    logic         tq1, ti1, te1, en1, busy1, done1, mis1;
    logic [0:0]   chain1 = '0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 cp = ~cp;

    // Scan chain models: shift from TI into cell 0 when TE, else capture ~Q.
    always @(posedge cp) begin
        if (te) chain <= {chain[N-2:0], ti};
        else    chain <= ~chain;
    end
    assign chain_tq = chain[N-1];

    always @(posedge cp) begin
        if (te1) chain1 <= ti1;
        else     chain1 <= ~chain1;
    end
    assign tq1 = chain1[0];

    always @(posedge cp) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    edge_scan_ctrl #(.CHAIN_LEN(N)) dut0 (
        .CP(cp), .RN(rn), .start(start), .pat_in(pat_in), .exp_in(exp_in),
        .chain_tq(chain_tq), .TI(ti), .TE(te), .en(en), .busy(busy),
        .done(done), .cap_out(cap_out), .mismatch(mismatch)
    );

    edge_scan_ctrl #(.CHAIN_LEN(1)) dut1 (
        .CP(cp), .RN(rn), .start(start1), .pat_in(pat1), .exp_in(exp1),
        .chain_tq(tq1), .TI(ti1), .TE(te1), .en(en1), .busy(busy1),
        .done(done1), .cap_out(cap1), .mismatch(mis1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Returns at the negedge of run cycle 2 (first LOAD cycle).
    task automatic start_run(input logic [N-1:0] p, input logic [N-1:0] e);
        @(negedge cp);
        pat_in = p;
        exp_in = e;
        start  = 1'b1;
        @(negedge cp);
        start  = 1'b0;
    endtask

    // Counts run cycles (cycle 1 = the accepting IDLE cycle) until done.
    task automatic wait_done(input int c0, output int cyc, output int te_n);
        cyc  = c0;
        te_n = 0;
        while (!done && cyc < 200) begin
            te_n += int'(te);
            @(negedge cp);
            cyc++;
        end
    endtask

    initial begin
        int cyc, te_n, d0, gap;

        rn = 1'b0; start = 1'b0; pat_in = '0; exp_in = '0;
        start1 = 1'b0; pat1 = '0; exp1 = '0;
        repeat (2) @(negedge cp);
        check("rst_ti",   ti,        0);
        check("rst_te",   te,        0);
        check("rst_en",   en,        1);
        check("rst_busy", busy,      0);
        check("rst_done", done,      0);
        check("rst_cap",  cap_out,   0);
        check("rst_mis",  mismatch,  0);
        check("rst_st",   dut0.state, S_IDLE);
        rn = 1'b1;
        @(negedge cp);

        // T1 basic run
        start_run(8'hA5, 8'h5A);
        check("t1_busy_run", busy, 1);
        wait_done(2, cyc, te_n);
        check("t1_cycles", cyc,      19);
        check("t1_te_len", te_n,     16);
        check("t1_cap",    cap_out,  8'h5A);
        check("t1_mis",    mismatch, 0);
        check("t1_busy",   busy,     0);
        check("t1_st",     dut0.state, S_DONE);
        @(negedge cp);
        check("t1_done_w", done,     0);
        check("t1_hold",   cap_out,  8'h5A);

        // T2 compare failure, chain left cleared
        start_run(8'h0F, 8'hF1);
        wait_done(2, cyc, te_n);
        check("t2_cycles", cyc,      19);
        check("t2_cap",    cap_out,  8'hF0);
        check("t2_mis",    mismatch, 1);
        check("t2_chain",  chain,    0);

        // T3 abort in LOAD, then a clean run
        start_run(8'h3C, 8'hC3);
        repeat (3) @(negedge cp);
        check("t3_te_load", te, 1);
        check("t3_en_load", en, 0);
        d0 = done_cnt;
        #2 rn = 1'b0;
        #1;
        check("t3_te",   te,   0);
        check("t3_en",   en,   1);
        check("t3_busy", busy, 0);
        check("t3_st",   dut0.state, S_IDLE);
        @(negedge cp);
        rn = 1'b1;
        repeat (3) @(negedge cp);
        check("t3_no_done", done_cnt - d0, 0);
        start_run(8'hC3, 8'h3C);
        wait_done(2, cyc, te_n);
        check("t3_cycles", cyc,      19);
        check("t3_cap",    cap_out,  8'h3C);
        check("t3_mis",    mismatch, 0);

        // T4 start during UNLOAD is ignored
        start_run(8'h96, 8'h69);
        repeat (10) @(negedge cp);
        check("t4_unload", dut0.state, S_UNLOAD);
        pat_in = 8'hFF;
        exp_in = 8'h00;
        start  = 1'b1;
        @(negedge cp);
        start  = 1'b0;
        d0 = done_cnt;
        wait_done(13, cyc, te_n);
        check("t4_cycles", cyc,      19);
        check("t4_cap",    cap_out,  8'h69);
        check("t4_mis",    mismatch, 0);
        repeat (30) @(negedge cp);
        check("t4_one_run", done_cnt - d0, 1);
        check("t4_idle",    busy,          0);

        // T5 start held high: done-to-done spacing is the 19-cycle run
        @(negedge cp);
        pat_in = 8'h81;
        exp_in = 8'h7E;
        start  = 1'b1;
        wait_done(1, cyc, te_n);
        check("t5_first", cyc, 19);
        for (int k = 0; k < 2; k++) begin
            @(negedge cp);
            check("t5_done_w", done, 0);
            gap = 1;
            while (!done && gap < 200) begin
                @(negedge cp);
                gap++;
            end
            check("t5_gap", gap,     19);
            check("t5_cap", cap_out, 8'h7E);
        end
        @(negedge cp);
        start = 1'b0;
        repeat (25) @(negedge cp);
        check("t5_stop", busy, 0);

        // T6 single-cell chain
        @(negedge cp);
        pat1 = 1'b1; exp1 = 1'b0; start1 = 1'b1;
        @(negedge cp);
        start1 = 1'b0;
        cyc = 2;
        while (!done1 && cyc < 50) begin
            @(negedge cp);
            cyc++;
        end
        check("t6_cycles", cyc,  5);
        check("t6_cap",    cap1, 0);
        check("t6_mis",    mis1, 0);
        @(negedge cp);
        pat1 = 1'b0; exp1 = 1'b0; start1 = 1'b1;
        @(negedge cp);
        start1 = 1'b0;
        cyc = 2;
        while (!done1 && cyc < 50) begin
            @(negedge cp);
            cyc++;
        end
        check("t6b_cycles", cyc,  5);
        check("t6b_cap",    cap1, 1);
        check("t6b_mis",    mis1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
